branch_predictor: RTL and testbench

Parametrised branch target buffer (BTB) with 2-bit saturating direction counters. It replaces the static PC+4 next-PC choice in the five-stage RISC-V pipeline with a predicted next PC in Fetch. It is trained from Execute, flags mispredictions and supplies the redirect PC. It also keeps saturating branch and mispredict statistics counters.

---
 rtl/bp_pkg.sv | 18 +
 rtl/bp_counter2.sv | 22 ++
 rtl/branch_predictor.sv | 104 ++++++++++
 tb/tb_branch_predictor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared counter encodings and PC field helpers for the branch predictor
package bp_pkg;

    localparam logic [1:0] CTR_SN = 2'b00;
    localparam logic [1:0] CTR_WN = 2'b01;
    localparam logic [1:0] CTR_WT = 2'b10;
    localparam logic [1:0] CTR_ST = 2'b11;

    // Helpers work on a 64-bit container; callers cast the result down to IDXW/TAGW.
    function automatic logic [63:0] bp_index(input logic [63:0] pc, input int unsigned idxw);
        return (pc >> 2) & ((64'd1 << idxw) - 64'd1);
    endfunction

    function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int unsigned idxw);
        return pc >> (idxw + 2);
    endfunction

endpackage

// File: rtl/bp_counter2.sv
// rtl/bp_counter2.sv - next state of a 2-bit saturating direction counter
import bp_pkg::*;

module bp_counter2 (
    input  logic [1:0] state,
    input  logic       taken,
    input  logic       force_st,
    output logic [1:0] next
);

    always_comb begin
        next = state;
        if (force_st) begin
            next = CTR_ST;
        end else if (taken) begin
            if (state != CTR_ST) next = state + 2'd1;
        end else begin
            if (state != CTR_SN) next = state - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit counters, mispredict detection and statistics
import bp_pkg::*;

module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int STATW   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_all,
    input  logic [XLEN-1:0]  pc_f,
    output logic             hit_f,
    output logic             pred_taken_f,
    output logic [XLEN-1:0]  pred_pc_f,
    input  logic             upd_valid,
    input  logic             upd_is_jump,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_pc,
    output logic             mispredict_e,
    output logic [XLEN-1:0]  redirect_pc_e,
    output logic [STATW-1:0] cnt_branches,
    output logic [STATW-1:0] cnt_mispredicts
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    logic [ENTRIES-1:0] valid;
    logic [TAGW-1:0]    tag_mem    [ENTRIES];
    logic [XLEN-1:0]    target_mem [ENTRIES];
    logic [1:0]         ctr_mem    [ENTRIES];

    logic [IDXW-1:0] idx_f, idx_u;
    logic [TAGW-1:0] tag_f, tag_u;
    logic            hit_u;
    logic [1:0]      ctr_next;
    logic [XLEN-1:0] actual_next;

    // Direction travels down the pipe only as part of upd_pred_pc.
    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken;

    assign idx_f = IDXW'(bp_index(64'(pc_f), IDXW));
    assign tag_f = TAGW'(bp_tag(64'(pc_f), IDXW));
    assign idx_u = IDXW'(bp_index(64'(upd_pc), IDXW));
    assign tag_u = TAGW'(bp_tag(64'(upd_pc), IDXW));

    assign hit_f        = valid[idx_f] && (tag_mem[idx_f] == tag_f);
    assign pred_taken_f = hit_f && ctr_mem[idx_f][1];
    assign pred_pc_f    = pred_taken_f ? target_mem[idx_f] : pc_f + XLEN'(4);

    assign actual_next   = upd_taken ? upd_target : upd_pc + XLEN'(4);
    assign mispredict_e  = upd_valid && (upd_pred_pc != actual_next);
    assign redirect_pc_e = upd_valid ? actual_next : '0;

    assign hit_u = valid[idx_u] && (tag_mem[idx_u] == tag_u);

    bp_counter2 u_counter (
        .state    (ctr_mem[idx_u]),
        .taken    (upd_taken),
        .force_st (upd_is_jump),
        .next     (ctr_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
                ctr_mem[i]    <= CTR_SN;
            end
        end else if (flush_all) begin
            valid <= '0;
        end else if (upd_valid) begin
            if (hit_u) begin
                ctr_mem[idx_u] <= ctr_next;
                if (upd_taken || upd_is_jump) target_mem[idx_u] <= upd_target;
            end else if (upd_taken) begin
                valid[idx_u]      <= 1'b1;
                tag_mem[idx_u]    <= tag_u;
                target_mem[idx_u] <= upd_target;
                ctr_mem[idx_u]    <= upd_is_jump ? CTR_ST : CTR_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_branches    <= '0;
            cnt_mispredicts <= '0;
        end else begin
            if (upd_valid && (cnt_branches != '1))
                cnt_branches <= cnt_branches + STATW'(1);
            if (mispredict_e && (cnt_mispredicts != '1))
                cnt_mispredicts <= cnt_mispredicts + STATW'(1);
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_all;
    logic [31:0] pc_f;
    logic        hit_f, pred_taken_f;
    logic [31:0] pred_pc_f;
    logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_pc;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;
    logic [3:0]  cnt_branches, cnt_mispredicts;

    int tests = 0;
    int fails = 0;

    branch_predictor #(.XLEN(32), .ENTRIES(16), .STATW(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .flush_all       (flush_all),
        .pc_f            (pc_f),
        .hit_f           (hit_f),
        .pred_taken_f    (pred_taken_f),
        .pred_pc_f       (pred_pc_f),
        .upd_valid       (upd_valid),
        .upd_is_jump     (upd_is_jump),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_pc     (upd_pred_pc),
        .mispredict_e    (mispredict_e),
        .redirect_pc_e   (redirect_pc_e),
        .cnt_branches    (cnt_branches),
        .cnt_mispredicts (cnt_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic jump, input logic [31:0] pc, input logic taken,
                       input logic [31:0] target, input logic [31:0] pred_pc);
        upd_valid      = 1'b1;
        upd_is_jump    = jump;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = target;
        upd_pred_pc    = pred_pc;
        upd_pred_taken = (pred_pc != pc + 32'd4);
    endtask

    initial begin
        reset = 1'b0; flush_all = 1'b0; pc_f = 32'h100;
        upd_valid = 1'b0; upd_is_jump = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hit", 32'(hit_f), 32'd0);
        chk("reset_pred_taken", 32'(pred_taken_f), 32'd0);
        chk("reset_pred_pc", pred_pc_f, 32'h104);
        chk("reset_cnt_br", 32'(cnt_branches), 32'd0);
        chk("reset_cnt_mp", 32'(cnt_mispredicts), 32'd0);
        reset = 1'b1;

        // first taken branch allocates at WT
        upd(1'b0, 32'h100, 1'b1, 32'h80, 32'h104);
        #1;
        chk("alloc_mispredict", 32'(mispredict_e), 32'd1);
        chk("alloc_redirect", redirect_pc_e, 32'h80);
        chk("alloc_no_bypass", 32'(hit_f), 32'd0);
        tick();
        upd_valid = 1'b0;
        #1;
        chk("alloc_hit", 32'(hit_f), 32'd1);
        chk("alloc_pred_taken", 32'(pred_taken_f), 32'd1);
        chk("alloc_pred_pc", pred_pc_f, 32'h80);
        chk("alloc_cnt_mp", 32'(cnt_mispredicts), 32'd1);
        chk("alloc_cnt_br", 32'(cnt_branches), 32'd1);
        chk("idle_redirect_zero", redirect_pc_e, 32'd0);

        // WT -> WN
        upd(1'b0, 32'h100, 1'b0, 32'h80, 32'h80);
        #1;
        chk("nt1_mispredict", 32'(mispredict_e), 32'd1);
        chk("nt1_redirect", redirect_pc_e, 32'h104);
        tick();
        upd_valid = 1'b0;
        #1;
        chk("nt1_hit", 32'(hit_f), 32'd1);
        chk("nt1_pred_taken", 32'(pred_taken_f), 32'd0);
        chk("nt1_pred_pc", pred_pc_f, 32'h104);

        // WN -> SN, then SN saturates
        upd(1'b0, 32'h100, 1'b0, 32'h80, 32'h104);
        #1;
        chk("nt2_mispredict", 32'(mispredict_e), 32'd0);
        tick();
        upd(1'b0, 32'h100, 1'b0, 32'h80, 32'h104);
        tick();
        upd_valid = 1'b0;
        #1;
        chk("sat_low_pred_taken", 32'(pred_taken_f), 32'd0);
        chk("sat_low_hit", 32'(hit_f), 32'd1);
        chk("nt_cnt_br", 32'(cnt_branches), 32'd4);
        chk("nt_cnt_mp", 32'(cnt_mispredicts), 32'd2);

        // alias: 0x140 shares index 0 with 0x100
        upd(1'b1, 32'h140, 1'b1, 32'h200, 32'h144);
        #1;
        chk("alias_redirect", redirect_pc_e, 32'h200);
        tick();
        upd_valid = 1'b0;
        #1;
        chk("alias_old_miss", 32'(hit_f), 32'd0);
        chk("alias_old_pred_pc", pred_pc_f, 32'h104);
        pc_f = 32'h140;
        #1;
        chk("alias_new_hit", 32'(hit_f), 32'd1);
        chk("alias_new_pred_pc", pred_pc_f, 32'h200);

        // flush wins over a concurrent allocation
        upd(1'b0, 32'h180, 1'b1, 32'h300, 32'h184);
        flush_all = 1'b1;
        tick();
        upd_valid = 1'b0;
        flush_all = 1'b0;
        #1;
        chk("flush_miss_140", 32'(hit_f), 32'd0);
        pc_f = 32'h180;
        #1;
        chk("flush_miss_180", 32'(hit_f), 32'd0);
        chk("flush_pred_pc", pred_pc_f, 32'h184);
        chk("flush_cnt_br", 32'(cnt_branches), 32'd6);
        chk("flush_cnt_mp", 32'(cnt_mispredicts), 32'd4);

        // PC+4 wraps modulo 2^32
        upd(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h40, 32'h0);
        pc_f = 32'hFFFF_FFFC;
        #1;
        chk("wrap_mispredict", 32'(mispredict_e), 32'd0);
        chk("wrap_redirect", redirect_pc_e, 32'h0);
        chk("wrap_pred_pc", pred_pc_f, 32'h0);
        tick();

        // 16 mispredicts saturate the 4-bit statistics
        for (int i = 0; i < 16; i++) begin
            upd(1'b0, 32'h200, 1'b1, 32'h80, 32'h204);
            tick();
        end
        upd_valid = 1'b0;
        #1;
        chk("sat_cnt_mp", 32'(cnt_mispredicts), 32'hF);
        chk("sat_cnt_br", 32'(cnt_branches), 32'hF);
        pc_f = 32'h200;
        #1;
        chk("pre_reset_hit", 32'(hit_f), 32'd1);

        // asynchronous reset mid-cycle
        upd(1'b0, 32'h100, 1'b1, 32'h80, 32'h104);
        reset = 1'b0;
        #1;
        chk("async_reset_hit", 32'(hit_f), 32'd0);
        chk("async_reset_pred_pc", pred_pc_f, 32'h204);
        chk("async_reset_cnt_br", 32'(cnt_branches), 32'd0);
        chk("async_reset_cnt_mp", 32'(cnt_mispredicts), 32'd0);
        chk("reset_mispredict_comb", 32'(mispredict_e), 32'd1);
        upd_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
